tmds_pll_reset_seq: RTL

TMDS_PLL_RESET_SEQ -- requirements
Module: tmds_pll_reset_seq

---
 rtl/tmds_pll_reset_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tmds_pll_reset_seq.sv
// Reset sequencer for the rPLL feeding the TMDS serializer: pulses the PLL reset, waits for a stable lock,
// then releases the serializer and pixel resets in order, with retry, timeout, fault and lock-loss tracking.
module tmds_pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP         = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       serdes_rst,
  output logic       pix_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  // Terminal counts: each phase counter runs 0..N-1 and never wraps.
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic               r_sync1, r_sync2;
  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [RETRY_W-1:0] r_retry, w_retry_next, w_retry_inc;
  logic [7:0]         r_lock_loss, w_lock_loss_next;
  logic               r_pll_reset, r_serdes_rst, r_pix_rst, r_clk_ready, r_fault;
  logic               w_pll_reset, w_serdes_rst, w_pix_rst, w_clk_ready, w_fault;
  logic               w_lock_s;

  assign w_lock_s    = r_sync2;
  assign w_retry_inc = r_retry + 1'b1;

  // NOTE: every combinational output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_cnt_next       = '0;
    w_retry_next     = r_retry;
    w_lock_loss_next = r_lock_loss;
    if (restart) begin
      w_next_state = S_PLL_RST;
      w_retry_next = '0;
    end else begin
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == RST_LAST) w_next_state = S_WAIT_LOCK;
          else                   w_cnt_next   = r_cnt + 1'b1;
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = S_STABLE;
          end else if (r_cnt == TO_LAST) begin
            w_retry_next = w_retry_inc;
            w_next_state = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_lock_s)                 w_next_state = S_WAIT_LOCK;
          else if (r_cnt == STABLE_LAST) w_next_state = S_RELEASE;
          else                           w_cnt_next   = r_cnt + 1'b1;
        end
        S_RELEASE: begin
          if (!w_lock_s)              w_next_state = S_PLL_RST;
          else if (r_cnt == GAP_LAST) w_next_state = S_RUN;
          else                        w_cnt_next   = r_cnt + 1'b1;
        end
        S_RUN: begin
          w_retry_next = '0;
          if (!w_lock_s) begin
            w_next_state     = S_PLL_RST;
            w_lock_loss_next = (r_lock_loss != 8'hFF) ? r_lock_loss + 8'd1 : r_lock_loss;
          end
        end
        S_FAULT: w_next_state = S_FAULT;
        default: w_next_state = S_PLL_RST;
      endcase
    end

    // NOTE: outputs are decoded from the next state and registered, so they line up with r_state
    // without any combinational path from an input to a port.
    w_pll_reset  = (w_next_state == S_PLL_RST) || (w_next_state == S_FAULT);
    w_serdes_rst = !((w_next_state == S_RELEASE) || (w_next_state == S_RUN));
    w_pix_rst    = (w_next_state != S_RUN);
    w_clk_ready  = (w_next_state == S_RUN);
    w_fault      = (w_next_state == S_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_lock_loss  <= '0;
      r_pll_reset  <= 1'b1;
      r_serdes_rst <= 1'b1;
      r_pix_rst    <= 1'b1;
      r_clk_ready  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_sync1      <= pll_lock;
      r_sync2      <= r_sync1;
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      r_lock_loss  <= w_lock_loss_next;
      r_pll_reset  <= w_pll_reset;
      r_serdes_rst <= w_serdes_rst;
      r_pix_rst    <= w_pix_rst;
      r_clk_ready  <= w_clk_ready;
      r_fault      <= w_fault;
    end
  end

  assign pll_reset     = r_pll_reset;
  assign serdes_rst    = r_serdes_rst;
  assign pix_rst       = r_pix_rst;
  assign clk_ready     = r_clk_ready;
  assign fault         = r_fault;
  assign state         = r_state;
  assign lock_loss_cnt = r_lock_loss;

endmodule
